spart_driver: RTL and testbench



---
 rtl/spart_pkg.sv | 37 +++
 rtl/spart_drv_fifo.sv | 61 ++++++
 rtl/spart_driver.sv | 183 ++++++++++++++++++
 tb/tb_spart_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: shared definitions for the SPART bus-master driver.
//   - SPART register addresses on ioaddr
//   - STATUS register bit positions
//   - driver FSM state encoding
//   - baud_div(): divisor for a baud select code at a given clock frequency
package spart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam int STAT_RDA = 0;  // receive data available
  localparam int STAT_TBR = 1;  // transmit buffer ready

  typedef enum logic [2:0] {
    ST_CFG_LO = 3'd0,
    ST_CFG_HI = 3'd1,
    ST_POLL   = 3'd2,
    ST_RX_RD  = 3'd3,
    ST_TX_WR  = 3'd4
  } state_t;

  // divisor = clk_hz / (16 * baud) - 1, truncated to 16 bits
  function automatic logic [15:0] baud_div(input logic [1:0] br_cfg,
                                           input int unsigned clk_hz);
    int unsigned baud;
    case (br_cfg)
      2'b00:   baud = 32'd4800;
      2'b01:   baud = 32'd9600;
      2'b10:   baud = 32'd19200;
      default: baud = 32'd38400;
    endcase
    return 16'(clk_hz / (32'd16 * baud) - 32'd1);
  endfunction

endpackage

// File: rtl/spart_drv_fifo.sv
// spart_drv_fifo: 4-entry x 8-bit FIFO holding bytes received from the SPART
// until they can be echoed back out.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write strobe and byte (ignored when full)
//   pop           discard the head entry (ignored when empty)
//   rdata         head entry (valid when !empty)
//   full, empty   occupancy flags
module spart_drv_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spart_driver.sv
// spart_driver: bus master that drives the SPART register interface in place
// of a processor. After reset it writes the baud divisor (DIV_LOW then
// DIV_HIGH), then polls STATUS; every received byte is read and echoed back
// through the data register. A change on br_cfg reprograms the divisor
// without losing bytes already held.
//
// Build option: define SPART_DRV_FIFO_EN to hold up to four bytes in a FIFO
// (spart_drv_fifo) instead of a single hold register.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   br_cfg    baud select (00=4800 01=9600 10=19200 11=38400), asynchronous
//   iocs      SPART chip select
//   iorw      1=read, 0=write
//   ioaddr    00=data 01=status 10=div low 11=div high
//   databus   bidirectional; driven here only during write cycles
//   rx_valid  one-cycle pulse after a byte is read from the SPART
//   rx_byte   last byte read, held between pulses
//   cfg_done  high once both divisor bytes are written for the current br_cfg
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       cfg_done
);

  state_t      state;
  logic        bus_en;     // low for the first cycle after reset: bus idle
  logic [1:0]  sync1;
  logic [1:0]  cfg_sync;
  logic [1:0]  cfg_lat;
  logic [15:0] divisor;
  logic [7:0]  wdata;
  logic        push;
  logic        pop;
  logic        hold_full;
  logic        hold_empty;
  logic [7:0]  hold_head;

  // Two-flop synchronizer for the switch inputs. Not reset, so the
  // reset branch below can latch the live switch setting.
  always_ff @(posedge clk) begin
    sync1    <= br_cfg;
    cfg_sync <= sync1;
  end

  always_comb begin
    divisor = baud_div(cfg_lat, CLK_HZ);
  end

  assign push = bus_en && (state == ST_RX_RD);
  assign pop  = bus_en && (state == ST_TX_WR);

`ifdef SPART_DRV_FIFO_EN
  spart_drv_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (databus),
    .pop   (pop),
    .rdata (hold_head),
    .full  (hold_full),
    .empty (hold_empty)
  );
`else
  logic       hold_valid;
  logic [7:0] hold_data;

  // Single-entry hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_data  <= databus;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign hold_full  = hold_valid;
  assign hold_empty = !hold_valid;
  assign hold_head  = hold_data;
`endif

  // Driver FSM: one bus transaction per state per cycle. Read data (status or
  // rx byte) is sampled from databus at the end of the read cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_CFG_LO;
      bus_en   <= 1'b0;
      cfg_done <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= 8'h00;
      cfg_lat  <= cfg_sync;
    end else begin
      rx_valid <= 1'b0;
      if (!bus_en) begin
        // idle cycle after reset; CFG_LO is issued next cycle
        bus_en <= 1'b1;
      end else begin
        case (state)
          ST_CFG_LO: state <= ST_CFG_HI;
          ST_CFG_HI: begin
            cfg_done <= 1'b1;
            state    <= ST_POLL;
          end
          ST_POLL: begin
            if (cfg_sync != cfg_lat) begin
              cfg_done <= 1'b0;
              cfg_lat  <= cfg_sync;
              state    <= ST_CFG_LO;
            end else if (!hold_empty && databus[STAT_TBR]) begin
              state <= ST_TX_WR;   // TX wins over RX when both are possible
            end else if (!hold_full && databus[STAT_RDA]) begin
              state <= ST_RX_RD;
            end else begin
              state <= ST_POLL;
            end
          end
          ST_RX_RD: begin
            rx_byte  <= databus;
            rx_valid <= 1'b1;
            state    <= ST_POLL;
          end
          ST_TX_WR: state <= ST_POLL;
          default: begin
            cfg_done <= 1'b0;
            state    <= ST_CFG_LO;
          end
        endcase
      end
    end
  end

  // Bus signals decoded from registered state only.
  always_comb begin
    iocs   = 1'b0;
    iorw   = 1'b1;
    ioaddr = ADDR_DATA;
    wdata  = 8'h00;
    if (bus_en) begin
      iocs = 1'b1;
      case (state)
        ST_CFG_LO: begin
          iorw   = 1'b0;
          ioaddr = ADDR_DIV_LO;
          wdata  = divisor[7:0];
        end
        ST_CFG_HI: begin
          iorw   = 1'b0;
          ioaddr = ADDR_DIV_HI;
          wdata  = divisor[15:8];
        end
        ST_POLL:  ioaddr = ADDR_STATUS;
        ST_RX_RD: ioaddr = ADDR_DATA;
        ST_TX_WR: begin
          iorw   = 1'b0;
          ioaddr = ADDR_DATA;
          wdata  = hold_head;
        end
        default: iocs = 1'b0;
      endcase
    end else begin
      iocs = 1'b0;
    end
  end

  assign databus = (iocs && !iorw) ? wdata : 8'bz;

endmodule

// File: tb/tb_spart_driver.sv
`timescale 1ns/1ps
module tb_spart_driver;

  localparam int unsigned CLK_HZ = 50_000_000;
`ifdef SPART_DRV_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       iocs, iorw, rx_valid, cfg_done;
  logic [1:0] ioaddr;
  logic [7:0] rx_byte;
  wire  [7:0] databus;

  int n_cmp = 0;
  int n_err = 0;

  spart_driver #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .iocs(iocs), .iorw(iorw),
    .ioaddr(ioaddr), .databus(databus), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .cfg_done(cfg_done)
  );

  always #10 clk = ~clk;

  // ---------------- SPART behavioural model ----------------
  logic       tbr = 1'b1;
  logic [7:0] rx_mem [256];
  int         wr_idx = 0;   // bytes offered by the "line"
  int         rd_idx = 0;   // bytes taken by the driver
  logic       rda_m;
  logic [7:0] rx_head;

  assign rda_m   = (rd_idx < wr_idx);
  assign rx_head = rx_mem[rd_idx[7:0]];
  assign databus = (iocs && iorw) ? ((ioaddr == 2'b01) ? {6'b0, tbr, rda_m} : rx_head) : 8'bz;

  logic [7:0] tx_q [$];    // bytes written to the data register
  logic [9:0] cfg_q [$];   // {addr, data} of other writes
  int         n_rd = 0;    // data-register reads

  always @(posedge clk) begin
    if (!rst && iocs) begin
      if (iorw) begin
        if (ioaddr == 2'b00) begin
          rd_idx <= rd_idx + 1;
          n_rd   <= n_rd + 1;
        end
      end else if (ioaddr == 2'b00) begin
        tx_q.push_back(databus);
      end else begin
        cfg_q.push_back({ioaddr, databus});
      end
    end
  end

  // Reference divisor straight from the baud table.
  function automatic logic [15:0] exp_div(input logic [1:0] c);
    int unsigned bauds [4];
    bauds = '{4800, 9600, 19200, 38400};
    return 16'(CLK_HZ / (16 * bauds[c]) - 1);
  endfunction

  task automatic offer(input logic [7:0] b);
    rx_mem[wr_idx[7:0]] = b;
    wr_idx++;
  endtask

  // Bounded wait for rx_valid at a negedge.
  task automatic wait_rx(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (rx_valid) ok = 1'b1;
    end
  endtask

  // Bounded wait until at least n data writes have been logged.
  task automatic wait_tx(input int n, output bit ok);
    for (int k = 0; k < 200 && tx_q.size() < n; k++) @(negedge clk);
    ok = (tx_q.size() >= n);
  endtask

  logic [1:0] cur_cfg = 2'b01;

  task automatic test_reset;
    rst = 1'b1; br_cfg = 2'b01; tbr = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b00) begin
      n_err++;
      $display("FAIL reset_bus: iocs=%b iorw=%b ioaddr=%b, want 0 1 00", iocs, iorw, ioaddr);
    end
    n_cmp++;
    if (rx_valid !== 1'b0 || rx_byte !== 8'h00 || cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: rx_valid=%b rx_byte=%h cfg_done=%b, want 0 00 0", rx_valid, rx_byte, cfg_done);
    end
  endtask

  task automatic test_config;
    logic [15:0] d;
    d = exp_div(2'b01);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b10 || databus !== d[7:0]) begin
      n_err++;
      $display("FAIL cfg_lo: iocs=%b iorw=%b ioaddr=%b data=%h, want 1 0 10 %h", iocs, iorw, ioaddr, databus, d[7:0]);
    end
    @(negedge clk);
    n_cmp++;
    if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b11 || databus !== d[15:8] || cfg_done !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_hi: iorw=%b ioaddr=%b data=%h cfg_done=%b, want 0 11 %h 0", iorw, ioaddr, databus, cfg_done, d[15:8]);
    end
    @(negedge clk);
    n_cmp++;
    if (cfg_done !== 1'b1 || iocs !== 1'b1 || iorw !== 1'b1 || ioaddr !== 2'b01) begin
      n_err++;
      $display("FAIL cfg_poll: cfg_done=%b iocs=%b iorw=%b ioaddr=%b, want 1 1 1 01", cfg_done, iocs, iorw, ioaddr);
    end
  endtask

  task automatic test_echo;
    logic [7:0] b;
    int t0;
    bit ok;
    tbr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      t0 = tx_q.size();
      offer(b);
      wait_rx(ok);
      n_cmp++;
      if (!ok || rx_byte !== b) begin
        n_err++;
        $display("FAIL echo_rx[%0d]: seen=%0d rx_byte=%h, want %h", i, ok, rx_byte, b);
      end
      n_cmp++;
      if (iocs !== 1'b1 || iorw !== 1'b1 || ioaddr !== 2'b01) begin
        n_err++;
        $display("FAIL echo_poll[%0d]: iorw=%b ioaddr=%b, want status read", i, iorw, ioaddr);
      end
      @(negedge clk);
      n_cmp++;
      if (rx_valid !== 1'b0 || iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b00 || databus !== b) begin
        n_err++;
        $display("FAIL echo_tx[%0d]: rx_valid=%b iorw=%b ioaddr=%b data=%h, want 0 0 00 %h", i, rx_valid, iorw, ioaddr, databus, b);
      end
      wait_tx(t0 + 1, ok);
      n_cmp++;
      if (!ok || tx_q[t0] !== b) begin
        n_err++;
        $display("FAIL echo_log[%0d]: logged=%0d, want %h", i, ok, b);
      end
    end
  endtask

  task automatic test_tbr_stall;
    int r0, t0;
    bit ok, seen;
    tbr = 1'b0;
    r0 = n_rd;
    t0 = tx_q.size();
    for (int j = 0; j <= CAP; j++) offer(8'h10 + 8'(j));
    repeat (40) @(negedge clk);
    n_cmp++;
    if (n_rd - r0 != CAP) begin
      n_err++;
      $display("FAIL stall_reads: got %0d data reads, want %0d", n_rd - r0, CAP);
    end
    n_cmp++;
    if (tx_q.size() != t0) begin
      n_err++;
      $display("FAIL stall_writes: got %0d data writes, want 0", tx_q.size() - t0);
    end
    tbr = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || databus !== 8'h10) begin
      n_err++;
      $display("FAIL stall_release: seen=%0d data=%h, want write of 10 within 2 cycles", seen, databus);
    end
    wait_tx(t0 + CAP + 1, ok);
    for (int j = 0; j <= CAP; j++) begin
      n_cmp++;
      if (!ok || tx_q[t0 + j] !== 8'h10 + 8'(j)) begin
        n_err++;
        $display("FAIL stall_order[%0d]: complete=%0d, want %h", j, ok, 8'h10 + 8'(j));
      end
    end
  endtask

  task automatic test_reconfig;
    logic [1:0]  nc;
    logic [7:0]  b;
    logic [15:0] d;
    int c0, t0;
    bit ok;
    for (int it = 0; it < 2; it++) begin
      if (it == 0) nc = 2'b11;
      else begin
        do nc = 2'($urandom_range(0, 3)); while (nc == cur_cfg);
      end
      d = exp_div(nc);
      tbr = 1'b0;
      b = 8'($urandom_range(0, 255));
      t0 = tx_q.size();
      offer(b);
      wait_rx(ok);
      c0 = cfg_q.size();
      br_cfg = nc;
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
        @(negedge clk);
        if (!cfg_done) ok = 1'b1;
      end
      n_cmp++;
      if (!ok || iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b10) begin
        n_err++;
        $display("FAIL reconf_start[%0d]: cfg_done_low=%0d iorw=%b ioaddr=%b, want div-low write", it, ok, iorw, ioaddr);
      end
      ok = 1'b0;
      for (int k = 0; k < 10 && !ok; k++) begin
        @(negedge clk);
        if (cfg_done) ok = 1'b1;
      end
      n_cmp++;
      if (!ok || cfg_q.size() != c0 + 2 || cfg_q[c0] !== {2'b10, d[7:0]} || cfg_q[c0 + 1] !== {2'b11, d[15:8]}) begin
        n_err++;
        $display("FAIL reconf_div[%0d]: done=%0d writes=%0d, want 10:%h then 11:%h", it, ok, cfg_q.size() - c0, d[7:0], d[15:8]);
      end
      n_cmp++;
      if (tx_q.size() != t0) begin
        n_err++;
        $display("FAIL reconf_hold[%0d]: %0d data writes while tbr=0, want 0", it, tx_q.size() - t0);
      end
      tbr = 1'b1;
      wait_tx(t0 + 1, ok);
      n_cmp++;
      if (!ok || tx_q[t0] !== b) begin
        n_err++;
        $display("FAIL reconf_tx[%0d]: sent=%0d, want %h", it, ok, b);
      end
      cur_cfg = nc;
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] b;
    int t0;
    bit ok, seen;
    tbr = 1'b0;
    b = 8'($urandom_range(1, 255));
    offer(b);
    wait_rx(ok);
    tbr = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL midtx_enter: no TX write seen, want one");
    end
    t0 = tx_q.size();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (iocs !== 1'b0 || iorw !== 1'b1 || ioaddr !== 2'b00 || rx_byte !== 8'h00 || cfg_done !== 1'b0 || rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midtx_reset: iocs=%b iorw=%b ioaddr=%b rx_byte=%h cfg_done=%b, want 0 1 00 00 0", iocs, iorw, ioaddr, rx_byte, cfg_done);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (iocs !== 1'b1 || iorw !== 1'b0 || ioaddr !== 2'b10) begin
      n_err++;
      $display("FAIL midtx_restart: iocs=%b iorw=%b ioaddr=%b, want 1 0 10", iocs, iorw, ioaddr);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (tx_q.size() != t0) begin
      n_err++;
      $display("FAIL midtx_drop: %0d data writes after reset, want 0", tx_q.size() - t0);
    end
  endtask

  initial begin
    test_reset;
    test_config;
    test_echo;
    test_tbr_stall;
    test_reconfig;
    test_reset_mid_tx;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
